est_update_serial: RTL and testbench

Measurement-update stage of the 2-state Kalman filter. It sits directly downstream of `est_output_serial` and consumes its predicted output Z = H·x̂⁻, together with the measurement z, the gain K and the prior estimate x̂⁻. It computes the innovation y = z − Z and the posterior estimate x̂⁺ = x̂⁻ + K·y. All four K·y products go through one shared signed multiplier under a small FSM.

---
 rtl/est_update_serial.sv | 140 ++++++++++++++
 tb/tb_est_update_serial.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/est_update_serial.sv
// Measurement-update stage of the 2-state Kalman filter: y = z - Z, x+ = x- + K*y.
// The four K*y products share one signed N x N multiplier sequenced by a small FSM.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module est_update_serial #(
   parameter int N    = `FXP_N,
   parameter int FRAC = `FXP_FRAC
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] z00,
   input  logic [N-1:0] z10,
   input  logic [N-1:0] Z00,
   input  logic [N-1:0] Z10,
   input  logic [N-1:0] k00,
   input  logic [N-1:0] k01,
   input  logic [N-1:0] k10,
   input  logic [N-1:0] k11,
   input  logic [N-1:0] x00,
   input  logic [N-1:0] x10,
   output logic         done,
   output logic [N-1:0] Y00,
   output logic [N-1:0] Y10,
   output logic [N-1:0] X00,
   output logic [N-1:0] X10
);

   typedef enum logic [2:0] {IDLE, SUB, M0, M1, M2, M3, DONE} state_t;

   localparam int W = 2*N + 2;
   localparam logic signed [W-1:0] SAT_HI = {{(N+3){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_LO = {{(N+3){1'b1}}, {(N-1){1'b0}}};

   function automatic logic [N-1:0] sat(input logic signed [W-1:0] v);
      if (v > SAT_HI)      return SAT_HI[N-1:0];
      else if (v < SAT_LO) return SAT_LO[N-1:0];
      else                 return v[N-1:0];
   endfunction

   state_t state, state_d;

   logic signed [N-1:0] z0_q, z1_q, zp0_q, zp1_q;
   logic signed [N-1:0] k00_q, k01_q, k10_q, k11_q;
   logic signed [N-1:0] x0_q, x1_q;
   logic signed [2*N:0] acc;

   logic                accept;
   logic signed [N-1:0] mul_a, mul_b, x_sel;
   logic signed [2*N-1:0] prod;
   logic signed [2*N:0] prod_ext, acc_add, acc_sh;
   logic signed [W-1:0] diff0, diff1, post;

   assign accept = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = SUB;
         SUB:     state_d = M0;
         M0:      state_d = M1;
         M1:      state_d = M2;
         M2:      state_d = M3;
         M3:      state_d = DONE;
         DONE:    state_d = start ? SUB : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand steering for the single shared multiplier and post-update adder.
   always_comb begin
      mul_a = k00_q;
      mul_b = Y00;
      x_sel = x1_q;
      case (state)
         M1: begin mul_a = k01_q; mul_b = Y10; x_sel = x0_q; end
         M2: begin mul_a = k10_q; mul_b = Y00; end
         M3: begin mul_a = k11_q; mul_b = Y10; end
         default: ;
      endcase
   end

   assign prod     = mul_a * mul_b;
   assign prod_ext = {prod[2*N-1], prod};
   assign acc_add  = acc + prod_ext;
   assign acc_sh   = acc_add >>> FRAC;
   assign post     = {{(N+2){x_sel[N-1]}}, x_sel} + {acc_sh[2*N], acc_sh};
   assign diff0    = {{(N+2){z0_q[N-1]}}, z0_q} - {{(N+2){zp0_q[N-1]}}, zp0_q};
   assign diff1    = {{(N+2){z1_q[N-1]}}, z1_q} - {{(N+2){zp1_q[N-1]}}, zp1_q};

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: operand registers are reset too, so an aborted operation leaves no stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z0_q  <= '0; z1_q  <= '0; zp0_q <= '0; zp1_q <= '0;
         k00_q <= '0; k01_q <= '0; k10_q <= '0; k11_q <= '0;
         x0_q  <= '0; x1_q  <= '0;
         acc   <= '0;
         done  <= 1'b0;
         Y00   <= '0; Y10 <= '0;
         X00   <= '0; X10 <= '0;
      end else begin
         done <= (state == M3);
         if (accept) begin
            z0_q  <= z00; z1_q  <= z10; zp0_q <= Z00; zp1_q <= Z10;
            k00_q <= k00; k01_q <= k01; k10_q <= k10; k11_q <= k11;
            x0_q  <= x00; x1_q  <= x10;
         end
         case (state)
            SUB: begin
               Y00 <= sat(diff0);
               Y10 <= sat(diff1);
            end
            M0, M2: acc <= prod_ext;
            M1: begin
               acc <= acc_add;
               X00 <= sat(post);
            end
            M3: begin
               acc <= acc_add;
               X10 <= sat(post);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_est_update_serial.sv
// Directed, table-driven bench for est_update_serial (N=16, FRAC=8, S=256),
// plus hand-written sequences for start-while-busy, back-to-back and mid-run reset.
module tb_est_update_serial;

   localparam int N    = 16;
   localparam int FRAC = 8;

   typedef struct {
      logic signed [N-1:0] z0, z1, zp0, zp1, k00, k01, k10, k11, x0, x1;
      logic signed [N-1:0] ey0, ey1, ex0, ex1;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] z00, z10, Z00, Z10, k00, k01, k10, k11, x00, x10;
   logic         done;
   logic [N-1:0] Y00, Y10, X00, X10;

   int checks = 0;
   int errors = 0;
   vec_t vecs[6];
   vec_t none;
   int cnt;

   est_update_serial #(.N(N), .FRAC(FRAC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .z00(z00), .z10(z10), .Z00(Z00), .Z10(Z10),
      .k00(k00), .k01(k01), .k10(k10), .k11(k11),
      .x00(x00), .x10(x10),
      .done(done), .Y00(Y00), .Y10(Y10), .X00(X00), .X10(X10)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int z0, z1, zp0, zp1, k00, k01, k10, k11,
                               x0, x1, ey0, ey1, ex0, ex1);
      vec_t v;
      v.z0 = 16'(z0);   v.z1 = 16'(z1);   v.zp0 = 16'(zp0); v.zp1 = 16'(zp1);
      v.k00 = 16'(k00); v.k01 = 16'(k01); v.k10 = 16'(k10); v.k11 = 16'(k11);
      v.x0 = 16'(x0);   v.x1 = 16'(x1);
      v.ey0 = 16'(ey0); v.ey1 = 16'(ey1); v.ex0 = 16'(ex0); v.ex1 = 16'(ex1);
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      z00 = v.z0;  z10 = v.z1;  Z00 = v.zp0; Z10 = v.zp1;
      k00 = v.k00; k01 = v.k01; k10 = v.k10; k11 = v.k11;
      x00 = v.x0;  x10 = v.x1;
   endtask

   // Called away from the rising edge; returns at the negedge where done is seen.
   // When cnt reaches inj_cnt, iv is applied and start pulsed for one edge.
   task automatic run(input vec_t v, input int inj_cnt, input vec_t iv, output int c);
      apply(v);
      start = 1'b1;
      @(posedge clk);
      c = 1;
      forever begin
         @(negedge clk);
         if (c == inj_cnt) begin
            apply(iv);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) break;
         if (c >= 20) break;
         @(posedge clk);
         c++;
      end
   endtask

   task automatic check_out(input string tag, input vec_t v);
      check({tag, " Y00"}, int'($signed(Y00)), int'(v.ey0));
      check({tag, " Y10"}, int'($signed(Y10)), int'(v.ey1));
      check({tag, " X00"}, int'($signed(X00)), int'(v.ex0));
      check({tag, " X10"}, int'($signed(X10)), int'(v.ex1));
   endtask

   task automatic check_zero(input string tag);
      check({tag, " done"}, int'(done), 0);
      check({tag, " Y00"}, int'(Y00), 0);
      check({tag, " Y10"}, int'(Y10), 0);
      check({tag, " X00"}, int'(X00), 0);
      check({tag, " X10"}, int'(X10), 0);
   endtask

   initial begin
      //            z0      z1     Z0      Z1    k00    k01  k10  k11   x0      x1      Y0      Y1      X0      X1
      vecs[0] = mk(512,   -256,  128,    64,   0,     0,   0,   0,    384,    -192,   384,    -320,   384,    -192);
      vecs[1] = mk(256,    256,  384,   -192,  256,   0,   0,   256,  384,    -192,   -128,   448,    256,    256);
      vecs[2] = mk(0,      0,    3,      0,    128,   0,   0,   0,    0,      0,      -3,     0,      -2,     0);
      vecs[3] = mk(32767, -32768, -32768, 32767, 256, 0,   0,   256,  32767,  -32768, 32767,  -32768, 32767,  -32768);
      vecs[4] = mk(-32768, -32768, 0,    0,  -32768, -32768, 0, 0,    0,      100,    -32768, -32768, 32767,  100);
      vecs[5] = mk(1000,  -500,  200,    100,  128,   64, -64,  512,  50,     -60,    800,    -600,   300,    -1460);
      none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(none);

      #3 rst_n = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run(vecs[i], 0, none, cnt);
         check($sformatf("vec%0d latency", i), cnt, 6);
         check_out($sformatf("vec%0d", i), vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d done pulse", i), int'(done), 0);
      end

      // start re-pulsed with new operands during M1 is ignored
      run(vecs[1], 3, vecs[5], cnt);
      check("busy latency", cnt, 6);
      check_out("busy", vecs[1]);
      // start on the DONE cycle runs the new operands back to back
      run(vecs[5], 0, none, cnt);
      check("b2b latency", cnt, 6);
      check_out("b2b", vecs[5]);
      @(negedge clk);

      // reset asserted during M2 clears everything without a clock edge
      apply(vecs[5]);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre-reset X00", int'($signed(X00)), 300);
      rst_n = 1'b0;
      #1 check_zero("midrun reset");
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) seen++;
         end
         check("no done after reset", seen, 0);
      end
      check_zero("post-reset idle");
      run(vecs[1], 0, none, cnt);
      check("fresh latency", cnt, 6);
      check_out("fresh", vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
